// File: rtl/matmul_seq_ctrl_if.sv
// Operand request / result handshake between the loop sequencer
// and the MAC datapath.
interface matmul_seq_ctrl_if #(
   parameter int ADDR_W = 12
);
   logic              op_valid;
   logic              op_ready;
   logic [ADDR_W-1:0] op_a_addr;
   logic [ADDR_W-1:0] op_b_addr;
   logic [ADDR_W-1:0] op_c_addr;
   logic              op_first;
   logic              op_last;
   logic              res_valid;

   modport master (
      output op_valid, op_a_addr, op_b_addr, op_c_addr,
      output op_first, op_last,
      input  op_ready, res_valid
   );

   modport slave (
      input  op_valid, op_a_addr, op_b_addr, op_c_addr,
      input  op_first, op_last,
      output op_ready, res_valid
   );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Matrix-multiply loop sequencer: walks i/j/k, issues one operand
// request per MAC and counts C write-backs before signalling done.
module matmul_seq_ctrl #(
   parameter int ADDR_W  = 12,
   parameter int MAX_DIM = 64,
   parameter int CNT_W   = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] cfg_m,
   input  logic [31:0] cfg_k,
   input  logic [31:0] cfg_n,
   output logic        done,
   output logic        busy,
   output logic        err,
   matmul_seq_ctrl_if.master op
);
   localparam int DIM_W = $clog2(MAX_DIM + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_FIN   = 2'd3;

   logic [1:0]        state;
   logic [DIM_W-1:0]  m_r, k_r, n_r;
   logic [DIM_W-1:0]  i_cnt, j_cnt, k_cnt;
   logic [ADDR_W-1:0] a_row;
   logic [CNT_W-1:0]  res_cnt, mn_r;

   logic              cfg_bad, hs, active;
   logic              last_k, last_j, last_i;
   logic [DIM_W-1:0]  k_nxt, j_nxt, i_nxt;
   logic [CNT_W-1:0]  res_inc;
   logic              res_hit;

   always_comb begin
      cfg_bad = (cfg_m == 32'd0) || (cfg_m > 32'(MAX_DIM)) ||
                (cfg_k == 32'd0) || (cfg_k > 32'(MAX_DIM)) ||
                (cfg_n == 32'd0) || (cfg_n > 32'(MAX_DIM));
      hs      = (state == S_RUN) && op.op_valid && op.op_ready;
      active  = (state == S_RUN) || (state == S_DRAIN);
      last_k  = k_cnt == k_r - DIM_W'(1);
      last_j  = j_cnt == n_r - DIM_W'(1);
      last_i  = i_cnt == m_r - DIM_W'(1);
      k_nxt   = k_cnt + DIM_W'(1);
      j_nxt   = j_cnt + DIM_W'(1);
      i_nxt   = i_cnt + DIM_W'(1);
      res_inc = res_cnt + CNT_W'(1);
      // covers a final result arriving in the same cycle as the check
      res_hit = (res_cnt == mn_r) ||
                (op.res_valid && res_inc == mn_r);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         done         <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
         op.op_valid  <= 1'b0;
         op.op_a_addr <= '0;
         op.op_b_addr <= '0;
         op.op_c_addr <= '0;
         op.op_first  <= 1'b0;
         op.op_last   <= 1'b0;
         m_r          <= '0;
         k_r          <= '0;
         n_r          <= '0;
         i_cnt        <= '0;
         j_cnt        <= '0;
         k_cnt        <= '0;
         a_row        <= '0;
         res_cnt      <= '0;
         mn_r         <= '0;
      end else begin
         done <= 1'b0;
         if (active && op.res_valid && res_cnt != mn_r)
            res_cnt <= res_inc;
         case (state)
            S_IDLE: if (start) begin
               m_r     <= cfg_m[DIM_W-1:0];
               k_r     <= cfg_k[DIM_W-1:0];
               n_r     <= cfg_n[DIM_W-1:0];
               mn_r    <= CNT_W'(cfg_m[DIM_W-1:0]) *
                          CNT_W'(cfg_n[DIM_W-1:0]);
               res_cnt <= '0;
               if (cfg_bad) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= S_FIN;
               end else begin
                  err          <= 1'b0;
                  busy         <= 1'b1;
                  i_cnt        <= '0;
                  j_cnt        <= '0;
                  k_cnt        <= '0;
                  a_row        <= '0;
                  op.op_valid  <= 1'b1;
                  op.op_a_addr <= '0;
                  op.op_b_addr <= '0;
                  op.op_c_addr <= '0;
                  op.op_first  <= 1'b1;
                  op.op_last   <= cfg_k[DIM_W-1:0] == DIM_W'(1);
                  state        <= S_RUN;
               end
            end
            S_RUN: if (hs) begin
               if (!last_k) begin
                  k_cnt        <= k_nxt;
                  op.op_a_addr <= op.op_a_addr + ADDR_W'(1);
                  op.op_b_addr <= op.op_b_addr + ADDR_W'(n_r);
                  op.op_first  <= 1'b0;
                  op.op_last   <= k_nxt == k_r - DIM_W'(1);
               end else begin
                  k_cnt        <= '0;
                  op.op_c_addr <= op.op_c_addr + ADDR_W'(1);
                  op.op_first  <= 1'b1;
                  op.op_last   <= k_r == DIM_W'(1);
                  if (!last_j) begin
                     j_cnt        <= j_nxt;
                     op.op_a_addr <= a_row;
                     op.op_b_addr <= ADDR_W'(j_nxt);
                  end else if (!last_i) begin
                     j_cnt        <= '0;
                     i_cnt        <= i_nxt;
                     a_row        <= a_row + ADDR_W'(k_r);
                     op.op_a_addr <= a_row + ADDR_W'(k_r);
                     op.op_b_addr <= '0;
                  end else begin
                     op.op_valid <= 1'b0;
                     op.op_first <= 1'b0;
                     op.op_last  <= 1'b0;
                     state       <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: if (res_hit) begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_FIN;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/matmul_seq_ctrl.md
# matmul_seq_ctrl

Loop sequencer for the matrix-multiply compute core, directly downstream of the AXI-Lite control register block. On a `start` pulse it latches `cfg_m`, `cfg_k` and `cfg_n`, validates them, then walks the i/j/k loop nest. For each multiply-accumulate it issues one operand request (A address, B address, C address, first/last flags) to the MAC datapath over a valid/ready handshake. It counts result write-backs and pulses `done`, which feeds the status register upstream.

## Interface
Parameters:
- `ADDR_W`, 12: width of the A, B and C buffer addresses.
- `MAX_DIM`, 64: largest legal value of M, K or N. Requires `MAX_DIM*MAX_DIM <= 2**ADDR_W`.
- `CNT_W`, 13: width of the result counter. Must hold `MAX_DIM*MAX_DIM`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle start pulse from the control block.
- `cfg_m` in 32: number of rows of A and C.
- `cfg_k` in 32: inner dimension.
- `cfg_n` in 32: number of columns of B and C.
- `done` out 1: single-cycle completion pulse, also issued on error.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `err` out 1: sticky configuration-error flag, cleared by the next accepted start.
- `op_valid` out 1: operand request valid.
- `op_ready` in 1: datapath accepts the request.
- `op_a_addr` out ADDR_W: A address, i*K+k.
- `op_b_addr` out ADDR_W: B address, k*N+j.
- `op_c_addr` out ADDR_W: C address, i*N+j.
- `op_first` out 1: k==0; the datapath clears its accumulator.
- `op_last` out 1: k==K-1; the datapath writes C after this MAC.
- `res_valid` in 1: one C element written back by the datapath.

## Operation
- States: IDLE, RUN, DRAIN, FIN.
- IDLE, `start`=1:
  - Latch M, K, N and clear the result counter.
  - If any dimension is 0 or greater than MAX_DIM: set `err`=1 and go to FIN. No operand requests are issued.
  - Otherwise clear `err`, set i=j=k=0 and go to RUN.
- `start` while not in IDLE is ignored. Latched configuration does not change during a run.
- RUN:
  - `op_valid`=1 with the current addresses and flags.
  - On a handshake (`op_valid && op_ready`), advance the loops: k++. On k wrap, k=0 and j++. On j wrap, j=0 and i++.
  - The handshake that carries i=M-1, j=N-1, k=K-1 moves the FSM to DRAIN.
- DRAIN: `op_valid`=0. When the result count reaches M*N, go to FIN.
- FIN: `done`=1 for one cycle, then IDLE.
- Result counting:
  - The counter increments on `res_valid` in RUN and DRAIN, and saturates at M*N.
  - `res_valid` in IDLE or FIN is ignored.
- Address arithmetic:
  - Addresses are computed incrementally with adders, not multipliers. `op_a_addr` steps by 1 per k. `op_b_addr` steps by N per k. Row bases step by K (A) and N (C) per i.
  - No wrap is possible inside legal configurations.
- Only the low bits of `cfg_*` needed for the MAX_DIM compare are stored. The upper bits participate only in the range check: any set upper bit means an error.

## Timing
- Reset values: `done`=0, `busy`=0, `err`=0, `op_valid`=0, all addresses 0, `op_first`=0, `op_last`=0. State is IDLE and all counters are 0.
- Reset asserted mid-run returns everything to these values immediately. No `done` is issued.
- All outputs are registered.
- Start latency: `start` at cycle t gives `op_valid`=1 and `busy`=1 at t+1.
- With `op_ready` held high, one request is issued per cycle. The total is M*K*N requests over M*K*N consecutive cycles.
- While `op_valid && !op_ready`, all `op_*` outputs are held stable.
- `done` is asserted one cycle after the final result is counted.
  - If the last `res_valid` coincides with the final op handshake, the FSM passes through DRAIN for one cycle.
- Error path: `start` at t gives `err`=1 and `done`=1 at t+1, with `busy`=0 throughout.
- `busy` falls in the same cycle that `done` rises.
- Back-to-back operation: a `start` in the cycle after `done` is accepted.

## Test plan
- M=K=N=2, `op_ready` tied high, `res_valid` pulsed after each op_last:
  - 8 requests.
  - (a,b,c) sequence: (0,0,0), (1,2,0), (0,1,1), (1,3,1), (2,0,2), (3,2,2), (2,1,3), (3,3,3).
  - `op_first`/`op_last` alternate.
  - `done` one cycle after the 4th `res_valid`.
- M=3, K=1, N=2: every op has `op_first`=`op_last`=1. Six requests with c=0..5. `done` after 6 results.
- Random `op_ready` backpressure (about 50%) on M=4, K=3, N=5: outputs stable while stalled, and exactly 60 handshakes in loop order. The result-order check must match the golden model.
- Error cases, each expecting `err`=1, `done`=1 at t+1, no `op_valid` and `busy`=0:
  - `cfg_k`=0
  - `cfg_n`=65
  - `cfg_m`=32'h0001_0002
  
  A following valid start clears `err`.
- Protocol edges:
  - `start` pulsed mid-run is ignored, and the run completes unchanged.
  - `rst` asserted mid-run clears all outputs in the same cycle, with no `done`.
  - Restart after reset produces a correct 2x2x2 sequence.
